// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to a 31-entry register file
// (r0 hardwired to zero) and serves two combinational read ports with write-through bypass.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-3:0] wb_fourPC,
    input  logic [1:0]        wb_jump,
    input  logic [1:0]        wb_memToReg,
    input  logic [DATA_W-1:0] wb_aluResult,
    input  logic [DATA_W-1:0] wb_readData,
    input  logic [ADDR_W:0]   wb_writeDataReg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_value,
    output logic              wb_we,
    output logic [CNT_W-1:0]  wr_count,
    output logic [1:0]        last_jump
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs-1:1];
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [1:0]        last_jump_q, last_jump_d;
    logic [ADDR_W-1:0] wr_idx;

    assign wr_idx = wb_writeDataReg[ADDR_W-1:0];

    always_comb begin
        wb_value = '0;
        unique case (wb_memToReg)
            2'b00:   wb_value = wb_aluResult;
            2'b01:   wb_value = wb_readData;
            2'b10:   wb_value = {wb_fourPC, 2'b00};
            default: wb_value = '0;
        endcase
    end

    // Bit ADDR_W of the destination is a guard: set means the slot carries no write.
    assign wb_we = (wb_memToReg != 2'b11) && !wb_writeDataReg[ADDR_W] && (wr_idx != '0);

    always_comb begin
        wr_count_d  = wr_count_q;
        last_jump_d = last_jump_q;
        if (wb_we) begin
            wr_count_d  = wr_count_q + CNT_W'(1);
            last_jump_d = wb_jump;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q  <= '0;
            last_jump_q <= 2'b00;
        end else begin
            if (wb_we) begin
                regs_q[wr_idx] <= wb_value;
            end
            wr_count_q  <= wr_count_d;
            last_jump_q <= last_jump_d;
        end
    end

    // Index 0 wins over the bypass so r0 stays zero even if a write to it is presented.
    always_comb begin
        rs_data = '0;
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_we && (rs_addr == wr_idx)) begin
            rs_data = wb_value;
        end else begin
            rs_data = regs_q[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_we && (rt_addr == wr_idx)) begin
            rt_data = wb_value;
        end else begin
            rt_data = regs_q[rt_addr];
        end
    end

    assign wr_count  = wr_count_q;
    assign last_jump = last_jump_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second instance with a 2-bit counter
// exercises counter wrap-around.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] wb_fourPC = '0;
    logic [1:0]  wb_jump = '0;
    logic [1:0]  wb_memToReg = 2'b11;
    logic [31:0] wb_aluResult = '0;
    logic [31:0] wb_readData = '0;
    logic [5:0]  wb_writeDataReg = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data, rt_data, wb_value;
    logic        wb_we;
    logic [31:0] wr_count;
    logic [1:0]  last_jump;

    logic [31:0] s_rs_data, s_rt_data, s_wb_value;
    logic        s_wb_we;
    logic [1:0]  s_wr_count;
    logic [1:0]  s_last_jump;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .wb_fourPC       (wb_fourPC),
        .wb_jump         (wb_jump),
        .wb_memToReg     (wb_memToReg),
        .wb_aluResult    (wb_aluResult),
        .wb_readData     (wb_readData),
        .wb_writeDataReg (wb_writeDataReg),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .wb_value        (wb_value),
        .wb_we           (wb_we),
        .wr_count        (wr_count),
        .last_jump       (last_jump)
    );

    wb_regfile #(.CNT_W(2)) u_small (
        .clk             (clk),
        .rst             (rst),
        .wb_fourPC       (wb_fourPC),
        .wb_jump         (wb_jump),
        .wb_memToReg     (wb_memToReg),
        .wb_aluResult    (wb_aluResult),
        .wb_readData     (wb_readData),
        .wb_writeDataReg (wb_writeDataReg),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rs_data         (s_rs_data),
        .rt_data         (s_rt_data),
        .wb_value        (s_wb_value),
        .wb_we           (s_wb_we),
        .wr_count        (s_wr_count),
        .last_jump       (s_last_jump)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] m2r, input logic [5:0] dest,
                         input logic [31:0] alu, input logic [1:0] jmp);
        wb_memToReg     = m2r;
        wb_writeDataReg = dest;
        wb_aluResult    = alu;
        wb_jump         = jmp;
    endtask

    initial begin
        // Reset state
        rs_addr = 5'd1;
        rt_addr = 5'd31;
        #2;
        chk("rst_rs", rs_data, 32'h0);
        chk("rst_rt", rt_data, 32'h0);
        chk("rst_cnt", wr_count, 32'h0);
        chk("rst_jump", {30'h0, last_jump}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Source select on r8
        wb_readData = 32'h2222_2222;
        wb_fourPC   = 30'h0010_0003;
        rs_addr     = 5'd8;
        drive(2'b00, 6'd8, 32'h1111_1111, 2'b00);
        #1;
        chk("sel_alu_val", wb_value, 32'h1111_1111);
        chk("sel_alu_we", {31'h0, wb_we}, 32'h1);
        step();
        chk("sel_cnt1", wr_count, 32'd1);
        drive(2'b01, 6'd8, 32'h1111_1111, 2'b00);
        #1;
        chk("sel_load_val", wb_value, 32'h2222_2222);
        step();
        drive(2'b10, 6'd8, 32'h1111_1111, 2'b00);
        #1;
        chk("sel_link_val", wb_value, 32'h0040_000C);
        step();
        drive(2'b11, 6'd8, 32'h1111_1111, 2'b00);
        #1;
        chk("sel_r8_stored", rs_data, 32'h0040_000C);
        chk("sel_cnt3", wr_count, 32'd3);
        chk("small_cnt3", {30'h0, s_wr_count}, 32'd3);

        // Bypass on r5, both ports; r8 unaffected
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        drive(2'b00, 6'd5, 32'hDEAD_BEEF, 2'b00);
        #1;
        chk("byp_rs", rs_data, 32'hDEAD_BEEF);
        chk("byp_rt", rt_data, 32'hDEAD_BEEF);
        rt_addr = 5'd8;
        #1;
        chk("byp_rt_other", rt_data, 32'h0040_000C);
        step();
        chk("small_wrap", {30'h0, s_wr_count}, 32'd0);
        rt_addr = 5'd5;
        drive(2'b11, 6'd5, 32'h0, 2'b00);
        #1;
        chk("byp_nowrite_we", {31'h0, wb_we}, 32'h0);
        chk("byp_nowrite_val", wb_value, 32'h0);
        chk("byp_rs_stored", rs_data, 32'hDEAD_BEEF);
        chk("byp_rt_stored", rt_data, 32'hDEAD_BEEF);
        chk("byp_cnt4", wr_count, 32'd4);

        // Zero register and guard bit
        rs_addr = 5'd0;
        rt_addr = 5'd3;
        drive(2'b00, 6'd0, 32'hFFFF_FFFF, 2'b01);
        #1;
        chk("r0_we", {31'h0, wb_we}, 32'h0);
        chk("r0_rs", rs_data, 32'h0);
        step();
        chk("r0_rs_after", rs_data, 32'h0);
        drive(2'b00, 6'b100011, 32'hFFFF_FFFF, 2'b01);
        #1;
        chk("guard_we", {31'h0, wb_we}, 32'h0);
        chk("guard_rt", rt_data, 32'h0);
        step();
        drive(2'b11, 6'd3, 32'hFFFF_FFFF, 2'b01);
        #1;
        chk("m2r11_we", {31'h0, wb_we}, 32'h0);
        chk("m2r11_rt", rt_data, 32'h0);
        step();
        chk("zero_rt_after", rt_data, 32'h0);
        chk("zero_cnt", wr_count, 32'd4);
        chk("zero_jump", {30'h0, last_jump}, 32'h0);

        // last_jump holds across a non-committing cycle
        drive(2'b00, 6'd9, 32'h1234_5678, 2'b10);
        step();
        chk("lj_commit", {30'h0, last_jump}, 32'h2);
        chk("lj_cnt5", wr_count, 32'd5);
        drive(2'b11, 6'd9, 32'h1234_5678, 2'b01);
        step();
        chk("lj_hold", {30'h0, last_jump}, 32'h2);
        chk("lj_cnt_hold", wr_count, 32'd5);
        chk("small_cnt1", {30'h0, s_wr_count}, 32'd1);

        // Asynchronous reset mid-cycle, then a write presented while in reset
        rs_addr = 5'd5;
        rt_addr = 5'd9;
        #1;
        chk("pre_rst_r5", rs_data, 32'hDEAD_BEEF);
        chk("pre_rst_r9", rt_data, 32'h1234_5678);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_r5", rs_data, 32'h0);
        chk("arst_r9", rt_data, 32'h0);
        chk("arst_cnt", wr_count, 32'h0);
        chk("arst_jump", {30'h0, last_jump}, 32'h0);
        drive(2'b00, 6'd7, 32'hAAAA_5555, 2'b11);
        step();
        rst = 1'b0;
        drive(2'b11, 6'd7, 32'hAAAA_5555, 2'b11);
        for (int i = 1; i < 32; i++) begin
            rs_addr = 5'(i);
            #1;
            chk($sformatf("arst_reg%0d", i), rs_data, 32'h0);
        end
        chk("arst_cnt_held", wr_count, 32'h0);
        chk("arst_jump_held", {30'h0, last_jump}, 32'h0);

        // Storage works again after reset
        rs_addr = 5'd31;
        drive(2'b01, 6'd31, 32'h0, 2'b01);
        wb_readData = 32'h0BAD_F00D;
        step();
        drive(2'b11, 6'd31, 32'h0, 2'b00);
        #1;
        chk("post_rst_r31", rs_data, 32'h0BAD_F00D);
        chk("post_rst_cnt", wr_count, 32'd1);
        chk("post_rst_jump", {30'h0, last_jump}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
